// File: rtl/memory_data_unit_if.sv
// CPU-bus / data-memory signal bundle for memory_data_unit.
// slave = the MDU itself; master = the CPU side plus memory model that drives it.
interface memory_data_unit_if #(
  parameter int DATA_W = 32
);
  logic              mdr_in;
  logic [DATA_W-1:0] bus_d;
  logic              read_req;
  logic              write_req;
  logic [1:0]        size;
  logic              sign_ext;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] q;

  modport slave (
    input  mdr_in, bus_d, read_req, write_req, size, sign_ext, mem_rdata, mem_ready,
    output mem_rd, mem_wr, mem_wdata, busy, done, err, q
  );

  modport master (
    output mdr_in, bus_d, read_req, write_req, size, sign_ext, mem_rdata, mem_ready,
    input  mem_rd, mem_wr, mem_wdata, busy, done, err, q
  );
endinterface

// File: rtl/memory_data_unit.sv
// Memory data register with IDLE/READ/WRITE/DONE memory handshake, sized + extended loads; MDU_TIMEOUT_EN adds a mem_ready timeout.
// Strobe from the request edge; done one cycle after mem_ready is sampled; requests while busy are dropped, not queued.
module memory_data_unit #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic               clk,
  input logic               clr,
  memory_data_unit_if.slave mdu
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] q_r, q_nxt;
  logic              rd_r, rd_nxt;
  logic              wr_r, wr_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;
  logic [1:0]        size_r, size_nxt;
  logic              sx_r, sx_nxt;

`ifdef MDU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt, cnt_nxt;
  logic       err_r, err_nxt;
`endif

  // Byte/halfword: fill with the extension bit, then overlay the low bits.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] d,
                                                input logic [1:0]        sz,
                                                input logic              sx);
    logic [DATA_W-1:0] r;
    case (sz)
      SZ_BYTE: begin
        r      = {DATA_W{sx & d[7]}};
        r[7:0] = d[7:0];
      end
      SZ_HALF: begin
        r       = {DATA_W{sx & d[15]}};
        r[15:0] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    done_nxt  = 1'b0;
    size_nxt  = size_r;
    sx_nxt    = sx_r;
`ifdef MDU_TIMEOUT_EN
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (mdu.read_req) begin
          state_nxt = READ;
          rd_nxt    = 1'b1;
          size_nxt  = mdu.size;
          sx_nxt    = mdu.sign_ext;
`ifdef MDU_TIMEOUT_EN
          cnt_nxt   = 8'd0;
`endif
        end else if (mdu.write_req) begin
          state_nxt = WRITE;
          wr_nxt    = 1'b1;
`ifdef MDU_TIMEOUT_EN
          cnt_nxt   = 8'd0;
`endif
        end else if (mdu.mdr_in) begin
          q_nxt = mdu.bus_d;
        end
      end
      READ: begin
        if (mdu.mem_ready) begin
          q_nxt     = fmt_load(mdu.mem_rdata, size_r, sx_r);
          state_nxt = DONE;
          done_nxt  = 1'b1;
`ifdef MDU_TIMEOUT_EN
        end else if (cnt == TO_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
          rd_nxt  = 1'b1;
        end
`else
        end else begin
          rd_nxt = 1'b1;
        end
`endif
      end
      WRITE: begin
        if (mdu.mem_ready) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
`ifdef MDU_TIMEOUT_EN
        end else if (cnt == TO_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
          wr_nxt  = 1'b1;
        end
`else
        end else begin
          wr_nxt = 1'b1;
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      q_r    <= '0;
      rd_r   <= 1'b0;
      wr_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      size_r <= 2'b00;
      sx_r   <= 1'b0;
`ifdef MDU_TIMEOUT_EN
      cnt    <= 8'd0;
      err_r  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      q_r    <= q_nxt;
      rd_r   <= rd_nxt;
      wr_r   <= wr_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      size_r <= size_nxt;
      sx_r   <= sx_nxt;
`ifdef MDU_TIMEOUT_EN
      cnt    <= cnt_nxt;
      err_r  <= err_nxt;
`endif
    end
  end

  // q only changes from IDLE or on read completion, so it is stable for the whole write.
  assign mdu.mem_wdata = q_r;
  assign mdu.q         = q_r;
  assign mdu.mem_rd    = rd_r;
  assign mdu.mem_wr    = wr_r;
  assign mdu.busy      = busy_r;
  assign mdu.done      = done_r;
`ifdef MDU_TIMEOUT_EN
  assign mdu.err       = err_r;
`else
  assign mdu.err       = 1'b0;
`endif

endmodule

// File: tb/tb_memory_data_unit.sv
// Bench for memory_data_unit: table of sized loads, scoreboard on done, hand sequences for reset, write collision and timeout.
module tb_memory_data_unit;

  logic clk;
  logic clr;

  memory_data_unit_if #(.DATA_W(32)) mif ();

  memory_data_unit #(
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .mdu (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0]  size;
    logic        sx;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_q;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!clr) begin
      if (mif.done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_q", mif.q, e.q);
          chk("sb_err", {31'd0, mif.err}, {31'd0, e.err});
        end
      end else if (mif.err) begin
        checks++;
        failures++;
        $display("FAIL err_without_done actual=1 required=0");
      end
    end
  end

  task automatic do_read(input logic [1:0] sz, input logic sx, input logic [31:0] rd,
                         input int lat, input logic [31:0] exp_q);
    @(negedge clk);
    mif.read_req  = 1'b1;
    mif.size      = sz;
    mif.sign_ext  = sx;
    mif.mem_rdata = rd;
    sb.push_back('{q: exp_q, err: 1'b0});
    @(negedge clk);
    mif.read_req = 1'b0;
    mif.size     = ~sz;
    mif.sign_ext = ~sx;
    for (int c = 1; c <= lat; c++) begin
      chk("rd_strobe", {31'd0, mif.mem_rd}, 32'd1);
      chk("rd_busy", {31'd0, mif.busy}, 32'd1);
      if (c == lat) mif.mem_ready = 1'b1;
      @(negedge clk);
    end
    mif.mem_ready = 1'b0;
    chk("rd_strobe_drop", {31'd0, mif.mem_rd}, 32'd0);
    chk("rd_done", {31'd0, mif.done}, 32'd1);
    @(negedge clk);
    chk("rd_done_clear", {31'd0, mif.done}, 32'd0);
    chk("rd_idle", {31'd0, mif.busy}, 32'd0);
  endtask

  task automatic bus_load(input logic [31:0] d);
    @(negedge clk);
    mif.mdr_in = 1'b1;
    mif.bus_d  = d;
    @(negedge clk);
    mif.mdr_in = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2'b00, 1'b0, 32'h12345678, 3, 32'h12345678};
    vecs[1] = '{2'b10, 1'b1, 32'h000080F0, 1, 32'hFFFFFFF0};
    vecs[2] = '{2'b10, 1'b0, 32'h000080F0, 2, 32'h000000F0};
    vecs[3] = '{2'b01, 1'b1, 32'h000080F0, 1, 32'hFFFF80F0};
    vecs[4] = '{2'b01, 1'b0, 32'h000080F0, 2, 32'h000080F0};
    vecs[5] = '{2'b11, 1'b1, 32'h80000001, 1, 32'h80000001};
    vecs[6] = '{2'b10, 1'b1, 32'h0000007F, 1, 32'h0000007F};
    vecs[7] = '{2'b01, 1'b1, 32'h00017FFF, 2, 32'h00007FFF};
    vecs[8] = '{2'b10, 1'b0, 32'hFFFFFF80, 1, 32'h00000080};
    vecs[9] = '{2'b00, 1'b1, 32'hCAFEF00D, 4, 32'hCAFEF00D};

    clr           = 1'b1;
    mif.mdr_in    = 1'b0;
    mif.bus_d     = '0;
    mif.read_req  = 1'b0;
    mif.write_req = 1'b0;
    mif.size      = 2'b00;
    mif.sign_ext  = 1'b0;
    mif.mem_rdata = '0;
    mif.mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_q", mif.q, 32'd0);
    chk("rst_busy", {31'd0, mif.busy}, 32'd0);
    chk("rst_rd", {31'd0, mif.mem_rd}, 32'd0);
    chk("rst_wr", {31'd0, mif.mem_wr}, 32'd0);
    chk("rst_done", {31'd0, mif.done}, 32'd0);
    chk("rst_err", {31'd0, mif.err}, 32'd0);
    clr = 1'b0;

    // Plain bus load into the MDR
    bus_load(32'hDEADBEEF);
    chk("load_q", mif.q, 32'hDEADBEEF);
    chk("load_busy", {31'd0, mif.busy}, 32'd0);

    // Reset in the middle of a read: everything clears at once, no done afterwards
    @(negedge clk);
    mif.read_req = 1'b1;
    @(negedge clk);
    mif.read_req = 1'b0;
    chk("midrd_strobe", {31'd0, mif.mem_rd}, 32'd1);
    repeat (2) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("midrd_q", mif.q, 32'd0);
    chk("midrd_rd", {31'd0, mif.mem_rd}, 32'd0);
    chk("midrd_busy", {31'd0, mif.busy}, 32'd0);
    chk("midrd_done", {31'd0, mif.done}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    mif.mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    mif.mem_ready = 1'b0;
    chk("midrd_idle", {31'd0, mif.busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i].size, vecs[i].sx, vecs[i].rdata, vecs[i].lat, vecs[i].exp_q);
      chk("vec_q", mif.q, vecs[i].exp_q);
    end

    // Write with bus load and read requests colliding while busy
    bus_load(32'hA5A5A5A5);
    @(negedge clk);
    mif.write_req = 1'b1;
    sb.push_back('{q: 32'hA5A5A5A5, err: 1'b0});
    @(negedge clk);
    mif.write_req = 1'b0;
    mif.mdr_in    = 1'b1;
    mif.bus_d     = 32'h1;
    mif.read_req  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      chk("wr_strobe", {31'd0, mif.mem_wr}, 32'd1);
      chk("wr_no_rd", {31'd0, mif.mem_rd}, 32'd0);
      chk("wr_wdata", mif.mem_wdata, 32'hA5A5A5A5);
      if (c == 3) mif.mem_ready = 1'b1;
      @(negedge clk);
    end
    mif.mem_ready = 1'b0;
    mif.mdr_in    = 1'b0;
    mif.read_req  = 1'b0;
    chk("wr_strobe_drop", {31'd0, mif.mem_wr}, 32'd0);
    chk("wr_done", {31'd0, mif.done}, 32'd1);
    @(negedge clk);
    chk("wr_q_kept", mif.q, 32'hA5A5A5A5);
    chk("wr_idle", {31'd0, mif.busy}, 32'd0);

    // Simultaneous read and write: the read wins
    @(negedge clk);
    mif.read_req  = 1'b1;
    mif.write_req = 1'b1;
    mif.size      = 2'b00;
    mif.mem_rdata = 32'h0BADF00D;
    sb.push_back('{q: 32'h0BADF00D, err: 1'b0});
    @(negedge clk);
    mif.read_req  = 1'b0;
    mif.write_req = 1'b0;
    chk("both_rd", {31'd0, mif.mem_rd}, 32'd1);
    chk("both_wr", {31'd0, mif.mem_wr}, 32'd0);
    mif.mem_ready = 1'b1;
    @(negedge clk);
    mif.mem_ready = 1'b0;
    @(negedge clk);
    chk("both_q", mif.q, 32'h0BADF00D);

    // Memory never answers
    @(negedge clk);
    mif.read_req = 1'b1;
`ifdef MDU_TIMEOUT_EN
    sb.push_back('{q: 32'h0BADF00D, err: 1'b1});
    @(negedge clk);
    mif.read_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("to_strobe", {31'd0, mif.mem_rd}, 32'd1);
      @(negedge clk);
    end
    chk("to_strobe_drop", {31'd0, mif.mem_rd}, 32'd0);
    chk("to_done", {31'd0, mif.done}, 32'd1);
    chk("to_err", {31'd0, mif.err}, 32'd1);
    @(negedge clk);
    chk("to_idle", {31'd0, mif.busy}, 32'd0);
    chk("to_q_kept", mif.q, 32'h0BADF00D);
`else
    @(negedge clk);
    mif.read_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("hang_busy", {31'd0, mif.busy}, 32'd1);
    chk("hang_rd", {31'd0, mif.mem_rd}, 32'd1);
    chk("hang_err", {31'd0, mif.err}, 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("hang_clear", {31'd0, mif.busy}, 32'd0);
`endif

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_data_unit.md
Name: memory_data_unit

Overview:
- Parametrised successor to the single-cycle memory data register (MDR).
- Holds the MDR value and loads it from the CPU bus.
- Runs the read/write handshake with data memory through a small FSM, with variable memory latency.
- Handles byte, halfword and word accesses; loads can be sign- or zero-extended.
- Sits between the internal CPU bus and the RAM/memory-controller port.

Parameters:
- DATA_W, 32, width of the MDR, bus and memory data paths. Must be a multiple of 16 and at least 16.
- TIMEOUT_CYCLES, 15, maximum cycles to wait for mem_ready. Used only when MDU_TIMEOUT_EN is defined. Legal range 1 to 255.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- mdr_in  in  1  load Q from bus_d (CPU bus write into MDR).
- bus_d  in  DATA_W  data from CPU bus.
- read_req  in  1  start a memory read into Q.
- write_req  in  1  start a memory write of Q.
- size  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- sign_ext  in  1  on loads: 1 sign-extends, 0 zero-extends.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the current access.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  write data, equal to Q.
- busy  out  1  FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.
- q  out  DATA_W  MDR contents.

Behaviour:
- Reset (clr=1, asynchronous): q=0, state=IDLE, and mem_rd, mem_wr, busy, done, err all 0.
  - An in-flight access is abandoned; no done pulse is issued for it.
- States: IDLE, READ, WRITE, DONE. All outputs are registered.
- IDLE: priority is read_req > write_req > mdr_in.
  - read_req: latch size and sign_ext, go to READ, mem_rd=1 from the next cycle.
  - write_req: go to WRITE, mem_wr=1 from the next cycle. mem_wdata=q, held stable.
  - mdr_in alone: q <= bus_d at full width, no extension. FSM stays in IDLE.
- READ: mem_rd stays high until mem_ready is sampled high. On that edge:
  - q <= formatted mem_rdata; mem_rd <= 0; go to DONE.
  - Byte: bits [7:0] extended to DATA_W. Halfword: bits [15:0] extended to DATA_W. Word: bits taken as-is.
- WRITE: mem_wr stays high until mem_ready is sampled high, then mem_wr <= 0 and go to DONE. q is unchanged.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy=1 in READ, WRITE and DONE.
- Latency: request sampled at edge 0 gives strobe high from edge 0.
  - mem_ready sampled high at edge N gives q updated and done=1 during cycle N+1.
  - Minimum request-to-done is 2 cycles, when mem_ready is already high at edge 1.
- Ignored inputs:
  - read_req, write_req and mdr_in while busy=1 are ignored; they are not queued.
  - mem_ready in IDLE or DONE is ignored.
  - Changes to size or sign_ext after the request edge have no effect.
- read_req and write_req asserted together in IDLE: the read wins and the write is dropped.

Optional Feature:
- Macro: MDU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to READ or WRITE and increments each cycle mem_ready is low.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still low, the strobe drops and the FSM goes to DONE.
  - done=1 and err=1 together for one cycle. q is unchanged.
  - If mem_ready is high on the timeout cycle, the access completes normally and err=0.
- Not defined:
  - No counter is built; the FSM waits indefinitely. err is tied to 0.

Test Plan:
- Reset mid-read: read_req, then assert clr 2 cycles later. Required: all outputs 0 immediately (asynchronous), q=0, no done pulse afterwards.
- Bus load: mdr_in=1, bus_d=0xDEADBEEF. Required: q=0xDEADBEEF next cycle, busy stays 0.
- Word read with latency 3: read_req with size=00, mem_rdata=0x12345678, mem_ready high at the 3rd strobe cycle. Required: mem_rd high for exactly 3 cycles, then q=0x12345678 and a single done pulse.
- Byte and halfword loads:
  - mem_rdata=0x000080F0, size=10, sign_ext=1: required q=0xFFFFFFF0.
  - Same data, sign_ext=0: required q=0x000000F0.
  - Same data, size=01, sign_ext=1: required q=0xFFFF80F0.
- Write plus collision: q=0xA5A5A5A5, write_req; then hold mdr_in=1 with bus_d=0x1 while busy.
  - Required: mem_wdata=0xA5A5A5A5 with mem_wr high until mem_ready, and q still 0xA5A5A5A5 after done.
- Timeout (MDU_TIMEOUT_EN, TIMEOUT_CYCLES=4): read_req with mem_ready held low. Required: mem_rd drops, done=1 and err=1 in the same cycle, q unchanged. Without the macro: busy stays high.
